// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one WIDTH-bit ALU between two requesters. In IDLE the block
// picks a winner (round-robin or fixed priority) and captures its
// operands. In EXEC it evaluates them and registers the result. In RESP
// it holds the result until the winner accepts it.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   reqN, opN, aN, bN    request + ALU op code and operands, N = 0/1
//   gntN                 one-cycle pulse: requester N's operands captured
//   rvalidN, rreadyN     result handshake towards requester N
//   res, zero, ovf       registered result, res==0 flag, signed overflow
//   busy                 FSM not in IDLE
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int RR_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    output logic             rvalid0,
    input  logic             rready0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             rvalid1,
    input  logic             rready1,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_XOR = 3'b011,
        OP_NOR = 3'b100, OP_SRL = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111
    } alu_op_t;

    state_t           state;
    logic             prio;
    logic             owner;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             winner;
    logic             owner_ready;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    // With both requests pending, round-robin hands the grant to prio;
    // fixed priority always favours requester 0.
    always_comb begin
        if (req0 && req1)
            winner = (RR_EN != 0) ? prio : 1'b0;
        else
            winner = req1;
    end

    // The non-owner's rready is deliberately ignored.
    assign owner_ready = owner ? rready1 : rready0;

    // NOTE: every signal assigned in this block gets a default first so no
    // op code leaves one unassigned, which would infer a latch.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (alu_op_t'(op_q))
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_ADD: begin
                alu_res = a_q + b_q;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_SRL: alu_res = b_q >> a_q[SHW-1:0];
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            default: alu_res = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every
    // register samples values from before this edge, regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio    <= 1'b0;
            owner   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            res     <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= winner;
                        op_q  <= winner ? op1 : op0;
                        a_q   <= winner ? a1 : a0;
                        b_q   <= winner ? b1 : b0;
                        gnt0  <= ~winner;
                        gnt1  <= winner;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    res     <= alu_res;
                    zero    <= (alu_res == '0);
                    ovf     <= alu_ovf;
                    rvalid0 <= ~owner;
                    rvalid1 <= owner;
                    state   <= RESP;
                end
                RESP: begin
                    if (owner_ready) begin
                        rvalid0 <= 1'b0;
                        rvalid1 <= 1'b0;
                        prio    <= ~owner;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter. Two instances: d=0 round-robin, d=1 fixed
// priority. Requester k = 2*d + p. Expected results are queued per
// instance in predicted service order and checked on each handshake.
module tb_alu_share_arbiter;

    typedef struct {
        bit          p;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        req [4];
    logic [2:0]  op [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic        gnt [4];
    logic        rvalid [4];
    logic        rready [4];
    logic [31:0] res_o [2];
    logic        zero_o [2];
    logic        ovf_o [2];
    logic        busy_o [2];

    exp_t  sb [2][$];
    item_t iq [4][$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .RR_EN(1)) u_rr (
        .clk(clk), .rst_n(rst_n[0]),
        .req0(req[0]), .op0(op[0]), .a0(a[0]), .b0(b[0]),
        .gnt0(gnt[0]), .rvalid0(rvalid[0]), .rready0(rready[0]),
        .req1(req[1]), .op1(op[1]), .a1(a[1]), .b1(b[1]),
        .gnt1(gnt[1]), .rvalid1(rvalid[1]), .rready1(rready[1]),
        .res(res_o[0]), .zero(zero_o[0]), .ovf(ovf_o[0]), .busy(busy_o[0])
    );

    alu_share_arbiter #(.WIDTH(32), .RR_EN(0)) u_fp (
        .clk(clk), .rst_n(rst_n[1]),
        .req0(req[2]), .op0(op[2]), .a0(a[2]), .b0(b[2]),
        .gnt0(gnt[2]), .rvalid0(rvalid[2]), .rready0(rready[2]),
        .req1(req[3]), .op1(op[3]), .a1(a[3]), .b1(b[3]),
        .gnt1(gnt[3]), .rvalid1(rvalid[3]), .rready1(rready[3]),
        .res(res_o[1]), .zero(zero_o[1]), .ovf(ovf_o[1]), .busy(busy_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(bit p, logic [2:0] o, logic [31:0] x, logic [31:0] y);
        exp_t e;
        e.p   = p;
        e.ovf = 1'b0;
        case (o)
            3'd0: e.res = x & y;
            3'd1: e.res = x | y;
            3'd2: begin
                e.res = x + y;
                e.ovf = (x[31] == y[31]) && (e.res[31] != x[31]);
            end
            3'd3: e.res = x ^ y;
            3'd4: e.res = ~(x | y);
            3'd5: e.res = y >> x[4:0];
            3'd6: begin
                e.res = x - y;
                e.ovf = (x[31] != y[31]) && (e.res[31] != x[31]);
            end
            default: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Queue a request for requester p of instance d and its expected result.
    task automatic add(input int d, input bit p, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
        item_t it;
        it.op = o; it.a = x; it.b = y;
        iq[2*d+p].push_back(it);
        sb[d].push_back(model(p, o, x, y));
    endtask

    // Requester behaviour: hold req with stable operands until gnt, then
    // either present the next item (req stays high) or drop req.
    task automatic serve(input int k);
        int n;
        while (iq[k].size() > 0) begin
            op[k]  = iq[k][0].op;
            a[k]   = iq[k][0].a;
            b[k]   = iq[k][0].b;
            req[k] = 1'b1;
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (!gnt[k] && n < 200);
            check($sformatf("gnt_wait%0d", k), {31'b0, gnt[k]}, 32'd1);
            if (gnt[k]) void'(iq[k].pop_front());
            else iq[k].delete();
        end
        req[k] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_idle_outs(input int d, input string tag);
        check({tag, "_gnt"},    {30'b0, gnt[2*d+1], gnt[2*d]}, 32'd0);
        check({tag, "_rvalid"}, {30'b0, rvalid[2*d+1], rvalid[2*d]}, 32'd0);
        check({tag, "_res"},    res_o[d], 32'd0);
        check({tag, "_flags"},  {29'b0, zero_o[d], ovf_o[d], busy_o[d]}, 32'd0);
    endtask

    // Scoreboard side: a handshake completes at the next edge when the
    // owner's rvalid and rready are both high.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d] && (rvalid[2*d] || rvalid[2*d+1])) begin
                bit p;
                p = rvalid[2*d+1];
                if (rvalid[2*d] && rvalid[2*d+1])
                    check($sformatf("both_rvalid_d%0d", d), 32'd1, 32'd0);
                if (rready[2*d+p]) begin
                    if (sb[d].size() == 0) begin
                        check($sformatf("unexpected_rvalid_d%0d", d), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb[d].pop_front();
                        check($sformatf("owner_d%0d", d), {31'b0, p}, {31'b0, e.p});
                        check($sformatf("res_d%0d", d), res_o[d], e.res);
                        check($sformatf("zero_d%0d", d), {31'b0, zero_o[d]}, {31'b0, e.zero});
                        check($sformatf("ovf_d%0d", d), {31'b0, ovf_o[d]}, {31'b0, e.ovf});
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req[k] = 1'b0; op[k] = '0; a[k] = '0; b[k] = '0; rready[k] = 1'b1;
        end
        cycles(3);
        check_idle_outs(0, "rst_rr");
        check_idle_outs(1, "rst_fp");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        cycles(1);

        // Single add with overflow: cycle-accurate latency checks.
        sb[0].push_back(model(1'b0, 3'b010, 32'h7FFF_FFFF, 32'd1));
        op[0] = 3'b010; a[0] = 32'h7FFF_FFFF; b[0] = 32'd1; req[0] = 1'b1;
        cycles(1);
        check("lat_gnt0",   {31'b0, gnt[0]}, 32'd1);
        check("lat_gnt1",   {31'b0, gnt[1]}, 32'd0);
        check("lat_rv_early", {31'b0, rvalid[0]}, 32'd0);
        check("lat_busy",   {31'b0, busy_o[0]}, 32'd1);
        req[0] = 1'b0;
        cycles(1);
        check("lat_gnt0_drop", {31'b0, gnt[0]}, 32'd0);
        check("lat_rvalid0", {31'b0, rvalid[0]}, 32'd1);
        check("lat_rvalid1", {31'b0, rvalid[1]}, 32'd0);
        check("lat_res",     res_o[0], 32'h8000_0000);
        check("lat_ovf",     {31'b0, ovf_o[0]}, 32'd1);
        cycles(1);
        check("lat_done", {30'b0, busy_o[0], rvalid[0]}, 32'd0);

        // NOR to zero from requester 1.
        add(0, 1'b1, 3'b100, 32'hFFFF_0000, 32'h0000_FFFF);
        serve(1);
        cycles(3);

        // Round-robin contention (prio is 0 here) and fixed priority, in parallel.
        add(0, 1'b0, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        add(0, 1'b1, 3'b001, 32'h0000_1234, 32'h5600_0000);
        add(0, 1'b0, 3'b101, 32'd36,        32'h8000_0000);
        add(0, 1'b1, 3'b110, 32'd5,         32'd9);
        add(1, 1'b0, 3'b010, 32'd100,       32'hFFFF_FFFF);
        add(1, 1'b0, 3'b011, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        add(1, 1'b0, 3'b101, 32'h0000_001F, 32'hFFFF_FFFF);
        add(1, 1'b1, 3'b111, 32'd5,         32'hFFFF_FFFD);
        fork
            serve(0);
            serve(1);
            serve(2);
            serve(3);
        join
        cycles(4);

        // Backpressure with slt; requester 1 waits for the handshake.
        add(0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'd1);
        add(0, 1'b1, 3'b011, 32'h1234_5678, 32'h0F0F_0F0F);
        rready[0] = 1'b0;
        fork
            serve(0);
            serve(1);
            begin
                n = 0;
                while (!rvalid[0] && n < 50) begin cycles(1); n++; end
                check("bp_rvalid_seen", {31'b0, rvalid[0]}, 32'd1);
                for (int i = 0; i < 5; i++) begin
                    check("bp_rvalid0", {31'b0, rvalid[0]}, 32'd1);
                    check("bp_res",     res_o[0], 32'd1);
                    check("bp_gnt1",    {31'b0, gnt[1]}, 32'd0);
                    if (i < 4) cycles(1);
                end
                rready[0] = 1'b1;
            end
        join
        cycles(3);

        // Lone requester 0: sub overflow, leaves prio = 1.
        add(0, 1'b0, 3'b110, 32'h8000_0000, 32'd1);
        serve(0);
        cycles(3);

        // Reset during EXEC: outputs clear at once, no response afterwards.
        op[1] = 3'b010; a[1] = 32'd1; b[1] = 32'd2; req[1] = 1'b1;
        cycles(1);
        check("mid_gnt1", {31'b0, gnt[1]}, 32'd1);
        rst_n[0] = 1'b0;
        req[1] = 1'b0;
        #1;
        check_idle_outs(0, "mid_rst");
        cycles(2);
        rst_n[0] = 1'b1;
        cycles(4);
        check_idle_outs(0, "post_rst");

        // Both request after reset: prio restarted at 0, so 0 then 1.
        add(0, 1'b0, 3'b010, 32'd7, 32'd8);
        add(0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_00FF);
        fork
            serve(0);
            serve(1);
        join

        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 100) begin
            cycles(1); n++;
        end
        check("sb_rr_left", sb[0].size(), 32'd0);
        check("sb_fp_left", sb[1].size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
